// File: rtl/lex_pkg.sv
// lex_pkg: shared types for the tile load/execute sequencer.
// Holds the descriptor mode and FSM state enums, the latched descriptor
// struct (sized by the package default widths) and small helper functions.
package lex_pkg;

    localparam int LEX_ADDR_W = 32;
    localparam int LEX_SIZE_W = 5;

    typedef enum logic [1:0] {
        LEX_FW = 2'd0,
        LEX_VW = 2'd1,
        LEX_HW = 2'd2,
        LEX_IW = 2'd3
    } lex_mode_e;

    typedef enum logic [1:0] {
        LEX_IDLE   = 2'd0,
        LEX_LOAD_B = 2'd1,
        LEX_LOAD_A = 2'd2,
        LEX_STORE  = 2'd3
    } lex_state_e;

    // Only the fields still needed after launch are kept; the B base and
    // stride go straight into the address generator in the launch cycle.
    typedef struct packed {
        logic [LEX_ADDR_W-1:0] a_addr;
        logic [LEX_ADDR_W-1:0] a_stride;
        logic [LEX_SIZE_W-1:0] m;
        logic [LEX_SIZE_W-1:0] k;
        logic [LEX_SIZE_W-1:0] n;
        logic                  store;
    } lex_desc_t;

    // A tile dimension is legal when it is nonzero and fits the array.
    function automatic logic lex_size_ok(input logic [LEX_SIZE_W-1:0] size,
                                         input logic [31:0] max_dim);
        return (size != '0) && (32'(size) <= max_dim);
    endfunction

    // High-importance modes may only launch while hi_ready is asserted.
    function automatic logic lex_needs_hi(input lex_mode_e mode);
        return (mode == LEX_HW) || (mode == LEX_IW);
    endfunction

endpackage

// File: rtl/tile_load_ex_ctrl_if.sv
// tile_load_ex_ctrl_if: shared memory request bus between the sequencer
// (master) and the memory port (slave). mem_ready is the slave's acceptance.
interface tile_load_ex_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
);
    logic              mem_en;
    logic              mem_we;
    logic [SIZE_W-1:0] mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;

    modport master (
        output mem_en,
        output mem_we,
        output mem_len,
        output mem_addr,
        input  mem_ready
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_len,
        input  mem_addr,
        output mem_ready
    );
endinterface

// File: rtl/lex_row_agen.sv
// lex_row_agen: row address generator shared by the B and A load phases.
// A load captures base, stride, direction and row count; each step moves the
// address by one stride (up or down, modulo 2^ADDR_W) and consumes one row.
// 'last' is high while the current row is the final one of the run.
module lex_row_agen #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_stride,
    input  logic              load_down,
    input  logic [SIZE_W-1:0] load_rows,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              down_q, down_d;
    logic [SIZE_W-1:0] rem_q, rem_d;

    // Next-state: a load wins over a step so a phase change can reseed in the
    // same cycle as the final beat of the previous phase.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        down_d   = down_q;
        rem_d    = rem_q;
        if (load) begin
            addr_d   = load_base;
            stride_d = load_stride;
            down_d   = load_down;
            rem_d    = load_rows;
        end else if (step && (rem_q != '0)) begin
            addr_d = down_q ? (addr_q - stride_q) : (addr_q + stride_q);
            rem_d  = rem_q - SIZE_W'(1);
        end
    end

    // Register the generator state; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            down_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            down_q   <= down_d;
            rem_q    <= rem_d;
        end
    end

    assign addr = addr_q;
    assign last = (rem_q == SIZE_W'(1));

endmodule

// File: rtl/tile_load_ex_ctrl.sv
// tile_load_ex_ctrl: load/execute sequencer for the systolic-array datapath.
// Pops tile descriptors, streams B rows (descending addresses) then A rows
// (ascending addresses) onto the shared memory bus, and optionally hands the
// bus to the store unit. Optional feature macro: LEX_PERF_CNT_EN enables the
// saturating busy/stall performance counters; without it both ports read 0.
// ADDR_W/SIZE_W must not exceed the lex_pkg default widths.
module tile_load_ex_ctrl
    import lex_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int SIZE_W    = 5,
    parameter int ARRAY_DIM = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_rd,
    input  logic [1:0]                cfg_mode,
    input  logic [ADDR_W-1:0]         cfg_a_addr,
    input  logic [ADDR_W-1:0]         cfg_b_addr,
    input  logic [ADDR_W-1:0]         cfg_a_stride,
    input  logic [ADDR_W-1:0]         cfg_b_stride,
    input  logic [SIZE_W-1:0]         cfg_m,
    input  logic [SIZE_W-1:0]         cfg_k,
    input  logic [SIZE_W-1:0]         cfg_n,
    input  logic                      cfg_store,
    input  logic                      hi_ready,
    tile_load_ex_ctrl_if.master       mem,
    output logic                      wfetch,
    output logic                      if_en,
    output logic                      prefetch_done,
    output logic                      can_store,
    input  logic                      st_mem_en,
    input  logic                      st_mem_we,
    input  logic [SIZE_W-1:0]         st_mem_len,
    input  logic [ADDR_W-1:0]         st_mem_addr,
    input  logic                      st_done,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      cfg_err,
    output logic [31:0]               perf_busy_cyc,
    output logic [31:0]               perf_stall_cyc
);

    lex_state_e state_q, state_d;
    lex_desc_t  desc_q, desc_d;

    logic              mem_en_c, mem_we_c;
    logic [SIZE_W-1:0] mem_len_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              accept;
    logic              live;
    logic              launch_ok;
    logic              desc_ok;
    lex_mode_e         mode_in;

    logic              agen_load, agen_down, agen_step, agen_last;
    logic [ADDR_W-1:0] agen_base, agen_stride, agen_addr;
    logic [SIZE_W-1:0] agen_rows;

    assign live      = !rst;
    assign mode_in   = lex_mode_e'(cfg_mode);
    assign launch_ok = cfg_valid && (!lex_needs_hi(mode_in) || hi_ready);
    assign desc_ok   = lex_size_ok(LEX_SIZE_W'(cfg_m), 32'(ARRAY_DIM)) &&
                       lex_size_ok(LEX_SIZE_W'(cfg_k), 32'(ARRAY_DIM)) &&
                       lex_size_ok(LEX_SIZE_W'(cfg_n), 32'(ARRAY_DIM));
    assign accept    = mem_en_c && mem.mem_ready;
    assign busy      = (state_q != LEX_IDLE);

    lex_row_agen #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W)
    ) u_agen (
        .clk         (clk),
        .rst         (rst),
        .load        (agen_load),
        .load_base   (agen_base),
        .load_stride (agen_stride),
        .load_down   (agen_down),
        .load_rows   (agen_rows),
        .step        (agen_step),
        .addr        (agen_addr),
        .last        (agen_last)
    );

    // Sequencer decode: launch/validation in IDLE, beat bookkeeping in the
    // load phases, store pass-through; pulses are suppressed during reset.
    always_comb begin
        state_d       = state_q;
        desc_d        = desc_q;
        cfg_rd        = 1'b0;
        cfg_err       = 1'b0;
        tile_done     = 1'b0;
        wfetch        = 1'b0;
        if_en         = 1'b0;
        prefetch_done = 1'b0;
        can_store     = 1'b0;
        mem_en_c      = 1'b0;
        mem_we_c      = 1'b0;
        mem_len_c     = '0;
        mem_addr_c    = '0;
        agen_load     = 1'b0;
        agen_base     = '0;
        agen_stride   = '0;
        agen_down     = 1'b0;
        agen_rows     = '0;
        agen_step     = 1'b0;
        case (state_q)
            LEX_IDLE: begin
                if (live && launch_ok) begin
                    cfg_rd = 1'b1;
                    if (!desc_ok) begin
                        cfg_err = 1'b1;
                    end else begin
                        desc_d.a_addr   = LEX_ADDR_W'(cfg_a_addr);
                        desc_d.a_stride = LEX_ADDR_W'(cfg_a_stride);
                        desc_d.m        = LEX_SIZE_W'(cfg_m);
                        desc_d.k        = LEX_SIZE_W'(cfg_k);
                        desc_d.n        = LEX_SIZE_W'(cfg_n);
                        desc_d.store    = cfg_store;
                        agen_load       = 1'b1;
                        agen_base       = cfg_b_addr;
                        agen_stride     = cfg_b_stride;
                        agen_down       = 1'b1;
                        agen_rows       = cfg_k;
                        state_d         = LEX_LOAD_B;
                    end
                end
            end
            LEX_LOAD_B: begin
                mem_en_c   = 1'b1;
                mem_len_c  = desc_q.n[SIZE_W-1:0];
                mem_addr_c = agen_addr;
                if (live && accept) begin
                    wfetch    = 1'b1;
                    agen_step = 1'b1;
                    if (agen_last) begin
                        prefetch_done = 1'b1;
                        agen_load     = 1'b1;
                        agen_base     = desc_q.a_addr[ADDR_W-1:0];
                        agen_stride   = desc_q.a_stride[ADDR_W-1:0];
                        agen_down     = 1'b0;
                        agen_rows     = desc_q.m[SIZE_W-1:0];
                        state_d       = LEX_LOAD_A;
                    end
                end
            end
            LEX_LOAD_A: begin
                mem_en_c   = 1'b1;
                mem_len_c  = desc_q.k[SIZE_W-1:0];
                mem_addr_c = agen_addr;
                if (live && accept) begin
                    if_en     = 1'b1;
                    agen_step = 1'b1;
                    if (agen_last) begin
                        if (desc_q.store) begin
                            state_d = LEX_STORE;
                        end else begin
                            tile_done = 1'b1;
                            state_d   = LEX_IDLE;
                        end
                    end
                end
            end
            LEX_STORE: begin
                can_store  = 1'b1;
                mem_en_c   = st_mem_en;
                mem_we_c   = st_mem_we;
                mem_len_c  = st_mem_len;
                mem_addr_c = st_mem_addr;
                if (live && st_done) begin
                    tile_done = 1'b1;
                    state_d   = LEX_IDLE;
                end
            end
            default: begin
                state_d = LEX_IDLE;
            end
        endcase
    end

    // FSM and latched descriptor; reset drops any in-flight tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEX_IDLE;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
        end
    end

    assign mem.mem_en   = mem_en_c;
    assign mem.mem_we   = mem_we_c;
    assign mem.mem_len  = mem_len_c;
    assign mem.mem_addr = mem_addr_c;

`ifdef LEX_PERF_CNT_EN
    logic [31:0] busy_cyc_q, busy_cyc_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic        stalled;

    assign stalled = ((state_q == LEX_LOAD_B) || (state_q == LEX_LOAD_A)) &&
                     mem_en_c && !mem.mem_ready;

    // Saturating increments for the busy and memory-stall counters.
    always_comb begin
        busy_cyc_d  = busy_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (busy && (busy_cyc_q != '1)) begin
            busy_cyc_d = busy_cyc_q + 32'd1;
        end
        if (stalled && (stall_cyc_q != '1)) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            busy_cyc_q  <= busy_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_busy_cyc  = busy_cyc_q;
    assign perf_stall_cyc = stall_cyc_q;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_tile_load_ex_ctrl.sv
// tb_tile_load_ex_ctrl: directed self-checking bench for tile_load_ex_ctrl.
// Inputs are driven 2 time units after each rising edge and outputs are
// sampled 1 unit later, well away from the active edge.
module tb_tile_load_ex_ctrl;

    localparam int ADDR_W    = 32;
    localparam int SIZE_W    = 5;
    localparam int ARRAY_DIM = 16;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_rd;
    logic [1:0]        cfg_mode;
    logic [ADDR_W-1:0] cfg_a_addr, cfg_b_addr, cfg_a_stride, cfg_b_stride;
    logic [SIZE_W-1:0] cfg_m, cfg_k, cfg_n;
    logic              cfg_store;
    logic              hi_ready;
    logic              wfetch, if_en, prefetch_done, can_store;
    logic              st_mem_en, st_mem_we;
    logic [SIZE_W-1:0] st_mem_len;
    logic [ADDR_W-1:0] st_mem_addr;
    logic              st_done;
    logic              busy, tile_done, cfg_err;
    logic [31:0]       perf_busy_cyc, perf_stall_cyc;

    int vectors;
    int miscompares;

    tile_load_ex_ctrl_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

    tile_load_ex_ctrl #(
        .ADDR_W    (ADDR_W),
        .SIZE_W    (SIZE_W),
        .ARRAY_DIM (ARRAY_DIM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_rd         (cfg_rd),
        .cfg_mode       (cfg_mode),
        .cfg_a_addr     (cfg_a_addr),
        .cfg_b_addr     (cfg_b_addr),
        .cfg_a_stride   (cfg_a_stride),
        .cfg_b_stride   (cfg_b_stride),
        .cfg_m          (cfg_m),
        .cfg_k          (cfg_k),
        .cfg_n          (cfg_n),
        .cfg_store      (cfg_store),
        .hi_ready       (hi_ready),
        .mem            (bus),
        .wfetch         (wfetch),
        .if_en          (if_en),
        .prefetch_done  (prefetch_done),
        .can_store      (can_store),
        .st_mem_en      (st_mem_en),
        .st_mem_we      (st_mem_we),
        .st_mem_len     (st_mem_len),
        .st_mem_addr    (st_mem_addr),
        .st_done        (st_done),
        .busy           (busy),
        .tile_done      (tile_done),
        .cfg_err        (cfg_err),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_desc(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] as, input logic [31:0] bs,
                            input logic [4:0] m, input logic [4:0] k, input logic [4:0] n,
                            input logic st);
        cfg_mode     = mode;
        cfg_a_addr   = a;
        cfg_b_addr   = b;
        cfg_a_stride = as;
        cfg_b_stride = bs;
        cfg_m        = m;
        cfg_k        = k;
        cfg_n        = n;
        cfg_store    = st;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_desc(2'd0, 32'h2000, 32'h1000, 32'h20, 32'h40, 5'd2, 5'd3, 5'd4, 1'b0);
        cfg_valid = 1'b1;
        tick();
        tick();
        #1;
        vectors++;
        if ({cfg_rd, busy, bus.mem_en, cfg_err} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %b expected 0000", {cfg_rd, busy, bus.mem_en, cfg_err});
        end
        tick();
        rst = 1'b0;
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if ({cfg_rd, busy, bus.mem_en, bus.mem_we, wfetch, if_en, prefetch_done, can_store,
             tile_done, cfg_err} !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0", {cfg_rd, busy, bus.mem_en, bus.mem_we,
                     wfetch, if_en, prefetch_done, can_store, tile_done, cfg_err});
        end
        vectors++;
        if ({bus.mem_len, bus.mem_addr, perf_busy_cyc, perf_stall_cyc} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_buses: len %h addr %h busy_cyc %0d stall_cyc %0d expected all 0",
                     bus.mem_len, bus.mem_addr, perf_busy_cyc, perf_stall_cyc);
        end
    endtask

    task automatic test_fw_basic();
        logic [31:0] exp_b [0:2];
        logic [31:0] exp_a [0:1];
        exp_b[0] = 32'h1000; exp_b[1] = 32'h0FC0; exp_b[2] = 32'h0F80;
        exp_a[0] = 32'h2000; exp_a[1] = 32'h2020;
        tick();
        set_desc(2'd0, 32'h2000, 32'h1000, 32'h20, 32'h40, 5'd2, 5'd3, 5'd4, 1'b0);
        cfg_valid = 1'b1;
        #1;
        vectors++;
        if ({cfg_rd, cfg_err, busy, bus.mem_en} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL fw_launch: got %b expected 1000", {cfg_rd, cfg_err, busy, bus.mem_en});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            cfg_valid = 1'b0;
            #1;
            vectors++;
            if ({bus.mem_en, bus.mem_we, wfetch, if_en, prefetch_done, tile_done, bus.mem_len, bus.mem_addr}
                !== {1'b1, 1'b0, 1'b1, 1'b0, (i == 2), 1'b0, 5'd4, exp_b[i]}) begin
                miscompares++;
                $display("[TB] FAIL fw_b_beat%0d: got addr %h len %0d flags %b expected addr %h len 4 pd %0d",
                         i, bus.mem_addr, bus.mem_len, {bus.mem_en, bus.mem_we, wfetch, if_en,
                         prefetch_done, tile_done}, exp_b[i], (i == 2));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            vectors++;
            if ({bus.mem_en, bus.mem_we, wfetch, if_en, prefetch_done, tile_done, bus.mem_len, bus.mem_addr}
                !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == 1), 5'd3, exp_a[i]}) begin
                miscompares++;
                $display("[TB] FAIL fw_a_beat%0d: got addr %h len %0d flags %b expected addr %h len 3 td %0d",
                         i, bus.mem_addr, bus.mem_len, {bus.mem_en, bus.mem_we, wfetch, if_en,
                         prefetch_done, tile_done}, exp_a[i], (i == 1));
            end
        end
        tick();
        #1;
        vectors++;
        if ({busy, bus.mem_en, tile_done, bus.mem_len, bus.mem_addr} !== '0) begin
            miscompares++;
            $display("[TB] FAIL fw_idle_after: got busy %b en %b td %b len %0d addr %h expected all 0",
                     busy, bus.mem_en, tile_done, bus.mem_len, bus.mem_addr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr [0:6];
        logic        rdy      [0:6];
        int          wf_count;
        int          td_count;
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h0FC0; exp_addr[2] = 32'h0FC0;
        exp_addr[3] = 32'h0FC0; exp_addr[4] = 32'h0F80; exp_addr[5] = 32'h2000;
        exp_addr[6] = 32'h2020;
        rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1;
        rdy[4] = 1'b1; rdy[5] = 1'b1; rdy[6] = 1'b1;
        wf_count = 0;
        td_count = 0;
        tick();
        set_desc(2'd1, 32'h2000, 32'h1000, 32'h20, 32'h40, 5'd2, 5'd3, 5'd4, 1'b0);
        cfg_valid = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            tick();
            cfg_valid = 1'b0;
            bus.mem_ready = rdy[i];
            #1;
            wf_count += int'(wfetch);
            td_count += int'(tile_done);
            vectors++;
            if ({bus.mem_en, bus.mem_addr, bus.mem_len} !== {1'b1, exp_addr[i], (i < 5) ? 5'd4 : 5'd3}) begin
                miscompares++;
                $display("[TB] FAIL bp_cycle%0d: got en %b addr %h len %0d expected en 1 addr %h",
                         i, bus.mem_en, bus.mem_addr, bus.mem_len, exp_addr[i]);
            end
        end
        tick();
        bus.mem_ready = 1'b1;
        #1;
        vectors++;
        if (wf_count !== 3 || td_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL bp_counts: got wfetch %0d tile_done %0d expected 3 and 1", wf_count, td_count);
        end
        vectors++;
`ifdef LEX_PERF_CNT_EN
        if (perf_stall_cyc !== 32'd2 || perf_busy_cyc !== 32'd12) begin
            miscompares++;
            $display("[TB] FAIL bp_perf: got stall %0d busy %0d expected 2 and 12", perf_stall_cyc, perf_busy_cyc);
        end
`else
        if (perf_stall_cyc !== 32'd0 || perf_busy_cyc !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL bp_perf: got stall %0d busy %0d expected 0 and 0", perf_stall_cyc, perf_busy_cyc);
        end
`endif
    endtask

    task automatic test_hi_ready_gate();
        tick();
        set_desc(2'd2, 32'h5000, 32'h6000, 32'h10, 32'h10, 5'd1, 5'd1, 5'd1, 1'b0);
        cfg_valid = 1'b1;
        hi_ready  = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            vectors++;
            if ({cfg_rd, busy, cfg_err} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL hi_gate_wait%0d: got rd/busy/err %b expected 000", i, {cfg_rd, busy, cfg_err});
            end
        end
        tick();
        hi_ready = 1'b1;
        #1;
        vectors++;
        if ({cfg_rd, cfg_err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL hi_gate_launch: got rd/err %b expected 10", {cfg_rd, cfg_err});
        end
        tick();
        cfg_valid = 1'b0;
        hi_ready  = 1'b0;
        #1;
        vectors++;
        if ({busy, wfetch, prefetch_done, bus.mem_addr} !== {3'b111, 32'h6000}) begin
            miscompares++;
            $display("[TB] FAIL hi_gate_b: got busy/wf/pd %b addr %h expected 111 addr 6000",
                     {busy, wfetch, prefetch_done}, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
        if ({if_en, tile_done, bus.mem_addr} !== {2'b11, 32'h5000}) begin
            miscompares++;
            $display("[TB] FAIL hi_gate_a: got if_en/td %b addr %h expected 11 addr 5000",
                     {if_en, tile_done}, bus.mem_addr);
        end
    endtask

    task automatic test_invalid_desc();
        tick();
        set_desc(2'd0, 32'h7000, 32'h8000, 32'h4, 32'h4, 5'd2, 5'd0, 5'd2, 1'b0);
        cfg_valid = 1'b1;
        #1;
        vectors++;
        if ({cfg_rd, cfg_err, busy} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL inv_k0: got rd/err/busy %b expected 110", {cfg_rd, cfg_err, busy});
        end
        tick();
        set_desc(2'd0, 32'h7000, 32'h8000, 32'h4, 32'h4, 5'd1, 5'd2, 5'd17, 1'b0);
        #1;
        vectors++;
        if ({cfg_rd, cfg_err, busy} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL inv_n17: got rd/err/busy %b expected 110", {cfg_rd, cfg_err, busy});
        end
        tick();
        set_desc(2'd0, 32'h7000, 32'h8000, 32'h4, 32'h4, 5'd1, 5'd2, 5'd16, 1'b0);
        #1;
        vectors++;
        if ({cfg_rd, cfg_err, busy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL inv_then_valid: got rd/err/busy %b expected 100", {cfg_rd, cfg_err, busy});
        end
        tick();
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if ({busy, bus.mem_len, bus.mem_addr} !== {1'b1, 5'd16, 32'h8000}) begin
            miscompares++;
            $display("[TB] FAIL inv_b0: got busy %b len %0d addr %h expected 1 16 8000",
                     busy, bus.mem_len, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
        if ({prefetch_done, bus.mem_addr} !== {1'b1, 32'h7FFC}) begin
            miscompares++;
            $display("[TB] FAIL inv_b1: got pd %b addr %h expected 1 7ffc", prefetch_done, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
        if ({tile_done, bus.mem_len, bus.mem_addr} !== {1'b1, 5'd2, 32'h7000}) begin
            miscompares++;
            $display("[TB] FAIL inv_a0: got td %b len %0d addr %h expected 1 2 7000",
                     tile_done, bus.mem_len, bus.mem_addr);
        end
    endtask

    task automatic test_store();
        tick();
        set_desc(2'd0, 32'h2000, 32'h1000, 32'h10, 32'h10, 5'd1, 5'd1, 5'd2, 1'b1);
        cfg_valid   = 1'b1;
        st_mem_en   = 1'b1;
        st_mem_we   = 1'b1;
        st_mem_len  = 5'd5;
        st_mem_addr = 32'h3000;
        st_done     = 1'b1;
        #1;
        vectors++;
        if (cfg_rd !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL st_launch: got rd %b expected 1", cfg_rd);
        end
        tick();
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if ({can_store, bus.mem_we, wfetch, bus.mem_addr} !== {3'b001, 32'h1000}) begin
            miscompares++;
            $display("[TB] FAIL st_b: got cs/we/wf %b addr %h expected 001 1000",
                     {can_store, bus.mem_we, wfetch}, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
        if ({can_store, if_en, tile_done, bus.mem_len, bus.mem_addr} !== {3'b010, 5'd1, 32'h2000}) begin
            miscompares++;
            $display("[TB] FAIL st_a: got cs/if/td %b len %0d addr %h expected 010 1 2000",
                     {can_store, if_en, tile_done}, bus.mem_len, bus.mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            st_done = (i == 3);
            #1;
            vectors++;
            if ({can_store, busy, bus.mem_en, bus.mem_we, tile_done, bus.mem_len, bus.mem_addr}
                !== {4'b1111, (i == 3), 5'd5, 32'h3000}) begin
                miscompares++;
                $display("[TB] FAIL st_pass%0d: got cs/busy/en/we/td %b len %0d addr %h expected 1111%0d 5 3000",
                         i, {can_store, busy, bus.mem_en, bus.mem_we, tile_done}, bus.mem_len,
                         bus.mem_addr, (i == 3));
            end
        end
        tick();
        #1;
        vectors++;
        if ({can_store, busy, bus.mem_en, bus.mem_we, tile_done, bus.mem_len, bus.mem_addr} !== '0) begin
            miscompares++;
            $display("[TB] FAIL st_idle: got cs/busy/en/we/td %b len %0d addr %h expected all 0",
                     {can_store, busy, bus.mem_en, bus.mem_we, tile_done}, bus.mem_len, bus.mem_addr);
        end
        st_done     = 1'b0;
        st_mem_en   = 1'b0;
        st_mem_we   = 1'b0;
        st_mem_len  = '0;
        st_mem_addr = '0;
    endtask

    task automatic test_reset_mid_tile();
        tick();
        set_desc(2'd0, 32'h2000, 32'h1000, 32'h20, 32'h40, 5'd2, 5'd3, 5'd4, 1'b0);
        cfg_valid = 1'b1;
        #1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        tick();
        rst       = 1'b1;
        cfg_valid = 1'b1;
        #1;
        vectors++;
        if ({cfg_rd, tile_done, cfg_err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_pulse: got rd/td/err %b expected 000", {cfg_rd, tile_done, cfg_err});
        end
        tick();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if ({cfg_rd, busy, bus.mem_en, bus.mem_we, wfetch, if_en, prefetch_done, can_store, tile_done,
             cfg_err, bus.mem_len, bus.mem_addr, perf_busy_cyc, perf_stall_cyc} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: got flags %b len %0d addr %h perf %0d/%0d expected all 0",
                     {cfg_rd, busy, bus.mem_en, bus.mem_we, wfetch, if_en, prefetch_done, can_store,
                      tile_done, cfg_err}, bus.mem_len, bus.mem_addr, perf_busy_cyc, perf_stall_cyc);
        end
        tick();
        set_desc(2'd3, 32'hA000, 32'h9000, 32'h8, 32'h8, 5'd1, 5'd1, 5'd1, 1'b0);
        cfg_valid = 1'b1;
        hi_ready  = 1'b1;
        #1;
        vectors++;
        if ({cfg_rd, cfg_err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rst_relaunch: got rd/err %b expected 10", {cfg_rd, cfg_err});
        end
        tick();
        cfg_valid = 1'b0;
        hi_ready  = 1'b0;
        #1;
        vectors++;
        if ({wfetch, bus.mem_addr} !== {1'b1, 32'h9000}) begin
            miscompares++;
            $display("[TB] FAIL rst_relaunch_b: got wf %b addr %h expected 1 9000", wfetch, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
        if ({tile_done, bus.mem_addr} !== {1'b1, 32'hA000}) begin
            miscompares++;
            $display("[TB] FAIL rst_relaunch_a: got td %b addr %h expected 1 a000", tile_done, bus.mem_addr);
        end
        tick();
        #1;
        vectors++;
`ifdef LEX_PERF_CNT_EN
        if (perf_busy_cyc !== 32'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_perf: got busy_cyc %0d busy %b expected 2 and 0", perf_busy_cyc, busy);
        end
`else
        if (perf_busy_cyc !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_perf: got busy_cyc %0d busy %b expected 0 and 0", perf_busy_cyc, busy);
        end
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        cfg_valid     = 1'b0;
        hi_ready      = 1'b0;
        bus.mem_ready = 1'b1;
        st_mem_en     = 1'b0;
        st_mem_we     = 1'b0;
        st_mem_len    = '0;
        st_mem_addr   = '0;
        st_done       = 1'b0;
        set_desc(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        $display("[TB] starting tile_load_ex_ctrl bench");
        test_reset();
        test_fw_basic();
        test_backpressure();
        test_hi_ready_gate();
        test_invalid_desc();
        test_store();
        test_reset_mid_tile();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_load_ex_ctrl.md
# tile_load_ex_ctrl

Parametrised load/execute sequencer for the systolic-array datapath. It pops tile descriptors from the configuration buffer and streams B-tile rows (weight prefetch) to the shared memory interface, then A-tile rows (execute). It hands the interface to the store unit when a store is requested. It adds back-pressure on the memory port, descriptor validation, and a per-mode gate on the high-importance ready signal.

## Interface
- `ADDR_W`, 32: byte-address width of all addresses and strides.
- `SIZE_W`, 5: width of the m/k/n size fields and of the `mem_len` output.
- `ARRAY_DIM`, 16: largest legal m, k or n; must satisfy 1 ≤ ARRAY_DIM ≤ 2^SIZE_W−1.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `cfg_valid` in 1: a descriptor is present at the head of the config buffer.
- `cfg_rd` out 1: one-cycle pop of the head descriptor.
- `cfg_mode` in 2: mode of the head descriptor (FW=0, VW=1, HW=2, IW=3).
- `cfg_a_addr`, `cfg_b_addr`, `cfg_a_stride`, `cfg_b_stride` in ADDR_W each: tile base addresses and row strides.
- `cfg_m`, `cfg_k`, `cfg_n` in SIZE_W each: tile dimensions.
- `cfg_store` in 1: store the result after execute.
- `hi_ready` in 1: HW/IW launch permission.
- `mem_en`, `mem_we` out 1: memory request valid and write flag.
- `mem_len` out SIZE_W: row length.
- `mem_addr` out ADDR_W: row address.
- `mem_ready` in 1: the memory accepts the request this cycle.
- `wfetch`, `if_en` out 1: accepted B beat and accepted A beat.
- `prefetch_done` out 1: pulse on the last accepted B beat.
- `can_store` out 1: the store unit owns the memory port.
- `st_mem_en`, `st_mem_we` in 1, `st_mem_len` in SIZE_W, `st_mem_addr` in ADDR_W: store-unit request.
- `st_done` in 1: the store unit has finished.
- `busy` out 1: state ≠ IDLE.
- `tile_done` out 1: tile-complete pulse.
- `cfg_err` out 1: pulse when a descriptor is dropped.
- `perf_busy_cyc`, `perf_stall_cyc` out 32: performance counters (see Configuration).

## Operation
- States: IDLE, LOAD_B, LOAD_A, STORE. The descriptor is latched into internal registers at launch.
- Launch, IDLE only: `cfg_valid` && (mode∈{FW,VW} || `hi_ready`). At launch:
  - `cfg_rd`=1.
  - Latch the head descriptor.
  - Row counter cleared.
  - Next state LOAD_B.
- Validation at launch: if any of m, k, n is 0 or > ARRAY_DIM:
  - `cfg_rd`=1 and `cfg_err`=1.
  - Nothing is latched; stay in IDLE.
- LOAD_B:
  - Request fields: `mem_en`=1, `mem_we`=0, `mem_len`=n.
  - Addresses descend: b_addr, b_addr−b_stride, …, for k rows.
  - When k beats have been accepted, go to LOAD_A.
- LOAD_A:
  - Request fields: `mem_en`=1, `mem_len`=k.
  - Addresses ascend: a_addr, a_addr+a_stride, …, for m rows.
  - After m accepted beats: if store is set, go to STORE. Otherwise pulse `tile_done` and go to IDLE.
- STORE:
  - `can_store`=1.
  - `mem_en`/`mem_we`/`mem_len`/`mem_addr` pass through from the `st_mem_*` inputs combinationally.
  - `st_done`=1 → `tile_done` pulse, go to IDLE.
- Beat acceptance is `mem_en` && `mem_ready`. The counter and address advance only on acceptance.
- `wfetch` = acceptance in LOAD_B. `if_en` = acceptance in LOAD_A.
- Address arithmetic is unsigned, modulo 2^ADDR_W; wrap-around is silent.
- `mem_len` carries the latched size zero-extended; no truncation.
- Outside LOAD_B, LOAD_A and STORE: `mem_en`=0, `mem_we`=0, `mem_len`=0, `mem_addr`=0.

## Timing
- Reset value of every output: 0.
- `rst` mid-tile:
  - Next state is IDLE.
  - Latched descriptor discarded; no `cfg_rd`, no `tile_done`.
  - Counters cleared.
- Launch cycle N → first B request valid in cycle N+1.
- Request hold: while `mem_ready`=0, `mem_addr` and `mem_len` hold stable and `mem_en` stays 1.
- With `mem_ready` held at 1, cycle counts from the launch cycle:
  - Tile without store: 1 + k + m cycles to `tile_done`.
  - The LOAD_B→LOAD_A transition adds no bubble: the first A request is valid the cycle after the last B acceptance.
- `prefetch_done` coincides with the k-th `wfetch`.
- `tile_done` is asserted in the final cycle of LOAD_A (no store) or in the `st_done` cycle. The next launch is no earlier than the following cycle, so there is a one-cycle IDLE bubble.
- `st_done` is only sampled in STORE.
- `hi_ready` is only sampled in IDLE.
- `cfg_valid` deasserting in a non-launch cycle has no effect.

## Configuration
- `LEX_PERF_CNT_EN` defined:
  - `perf_busy_cyc` increments every cycle `busy`=1.
  - `perf_stall_cyc` increments every cycle `mem_en` && !`mem_ready` in LOAD_B/LOAD_A.
  - Both saturate at 2^32−1 and clear on `rst`.
- Undefined: both ports are constant 0 and no counter flops are generated. Port list unchanged.

## Structure
- Package `lex_pkg` holds:
  - `lex_mode_e` (FW/VW/HW/IW).
  - `lex_state_e`.
  - Packed struct `lex_desc_t`, parametrised by `ADDR_W` and `SIZE_W` via the package's default widths.
- Sub-module `lex_row_agen`:
  - Loadable base address, up/down stride, row counter.
  - Outputs `addr` and `last`; advances on `step`.
  - Instantiated once and shared by LOAD_B and LOAD_A.

## Test plan
- FW, m=2, k=3, n=4, b_addr=0x1000, b_stride=0x40, a_addr=0x2000, a_stride=0x20, no store, `mem_ready`=1:
  - B requests to 0x1000/0x0FC0/0x0F80 with len 4.
  - Then A requests to 0x2000/0x2020 with len 3.
  - `prefetch_done` on the 3rd beat; `tile_done` 6 cycles after launch.
- Same tile with `mem_ready` low for 2 cycles on the 2nd B beat: address 0x0FC0 is held 3 cycles, `wfetch` count stays 3, `perf_stall_cyc`=2 with `LEX_PERF_CNT_EN`.
- HW descriptor with `hi_ready`=0 for 5 cycles: no `cfg_rd`; launch occurs in the first cycle `hi_ready`=1.
- Descriptor with k=0, then a valid descriptor: first one popped with a `cfg_err` pulse, second launches the cycle after.
- Store tile with `st_mem_addr`=0x3000, `st_mem_we`=1, `st_done` after 4 cycles:
  - `mem_addr`=0x3000 and `can_store`=1 throughout STORE.
  - `tile_done` pulses in the `st_done` cycle.
- `rst` asserted during LOAD_A: all outputs are 0 the next cycle and no `cfg_rd` is issued; the next descriptor launches normally.
